// File: rtl/crc_check_mblk.sv
// Multi-block CRC checker: slices each frame into NBLK payload blocks, runs an
// MSB-first CRC per block and compares it with the per-block CRC in the trailer.
module crc_check_mblk #(
  parameter int                   DATA_W      = 62,
  parameter int                   FRAME_BEATS = 26,
  parameter int                   NBLK        = 4,
  parameter logic [16*NBLK-1:0]   BLK_LEN_VEC = {16'd390, 16'd378, 16'd400, 16'd400},
  parameter int                   CRC_W       = 10,
  parameter logic [CRC_W-1:0]     POLY        = 10'b1000110011,
  parameter int                   TAIL_W      = 4,
  parameter int                   CNT_W       = 23
) (
  input  logic              clk_390p625M,
  input  logic              rst,
  input  logic              crc_en,
  input  logic [DATA_W-1:0] crc_data_in,
  input  logic              frame_tail_flag,
  input  logic              cnt_clr,
  output logic              check_valid,
  output logic              check_result,
  output logic [NBLK-1:0]   blk_fail,
  output logic              frame_len_err,
  output logic [CNT_W-1:0]  error_packet_cnt
);

  localparam int FRAME_BITS = FRAME_BEATS * DATA_W;
  localparam int BEAT_W     = $clog2(FRAME_BEATS + 1);

  function automatic int blk_len(input int b);
    return int'(BLK_LEN_VEC[(NBLK-1-b)*16 +: 16]);
  endfunction

  function automatic int pay_start(input int b);
    int s;
    s = 0;
    for (int k = 0; k < b; k++) s += blk_len(k);
    return s;
  endfunction

  function automatic int crc_start(input int b);
    return pay_start(NBLK) + b * CRC_W;
  endfunction

  if (pay_start(NBLK) + NBLK * CRC_W + TAIL_W != FRAME_BITS) begin : g_bad_cfg
    $fatal(1, "crc_check_mblk: block lengths, CRC fields and tail do not fill the frame");
  end

  typedef enum logic {IDLE, RUN} state_e;

  state_e              state_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [BEAT_W-1:0]   beat_cur;
  logic                fresh;
  logic                last_beat;
  logic                done;
  logic                len_err;
  logic                frame_fail;
  logic [NBLK-1:0]     blk_mis;
  int                  beat_base;

  // A beat seen in IDLE opens a new frame, so per-block state starts from zero.
  assign fresh      = (state_q == IDLE);
  assign beat_cur   = fresh ? '0 : beat_q;
  assign beat_base  = int'(beat_cur) * DATA_W;
  assign last_beat  = (beat_cur == BEAT_W'(FRAME_BEATS - 1));
  assign done       = frame_tail_flag | last_beat;
  assign len_err    = frame_tail_flag ^ last_beat;
  assign frame_fail = len_err | (|blk_mis);

  for (genvar b = 0; b < NBLK; b++) begin : g_blk
    localparam int P0 = pay_start(b);
    localparam int P1 = P0 + blk_len(b);
    localparam int C0 = crc_start(b);
    localparam int C1 = C0 + CRC_W;

    logic [CRC_W-1:0] lf_q, lf_d;
    logic [CRC_W-1:0] rx_q, rx_d;

    // Unrolled over the beat: each bit is steered by its absolute stream offset.
    always_comb begin
      logic [DATA_W-1:0] dsh;
      logic              din;
      logic              fb;
      int                s;
      lf_d = fresh ? '0 : lf_q;
      rx_d = fresh ? '0 : rx_q;
      dsh  = crc_data_in;
      din  = 1'b0;
      fb   = 1'b0;
      s    = beat_base;
      for (int unsigned j = 0; j < DATA_W; j++) begin
        din = dsh[DATA_W-1];
        dsh = dsh << 1;
        if (s >= P0 && s < P1) begin
          fb   = lf_d[CRC_W-1] ^ din;
          lf_d = {lf_d[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        if (s >= C0 && s < C1) rx_d = {rx_d[CRC_W-2:0], din};
        s++;
      end
    end

    always_ff @(posedge clk_390p625M) begin
      if (rst) begin
        lf_q <= '0;
        rx_q <= '0;
      end else if (crc_en) begin
        lf_q <= lf_d;
        rx_q <= rx_d;
      end
    end

    assign blk_mis[b] = (lf_d != rx_d);
  end

  always_ff @(posedge clk_390p625M) begin
    if (rst) begin
      state_q          <= IDLE;
      beat_q           <= '0;
      check_valid      <= 1'b0;
      check_result     <= 1'b1;
      blk_fail         <= '0;
      frame_len_err    <= 1'b0;
      error_packet_cnt <= '0;
    end else begin
      check_valid <= 1'b0;
      if (crc_en) begin
        if (done) begin
          state_q       <= IDLE;
          beat_q        <= '0;
          check_valid   <= 1'b1;
          check_result  <= ~frame_fail;
          blk_fail      <= len_err ? '1 : blk_mis;
          frame_len_err <= len_err;
        end else begin
          state_q <= RUN;
          beat_q  <= beat_cur + 1'b1;
        end
      end
      // A failing verdict coinciding with a clear counts as the first failure.
      if (crc_en && done && frame_fail)
        error_packet_cnt <= cnt_clr ? CNT_W'(1) :
                            (&error_packet_cnt) ? error_packet_cnt : error_packet_cnt + 1'b1;
      else if (cnt_clr)
        error_packet_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_crc_check_mblk.sv
// Randomized bench for crc_check_mblk: frames are built as bit arrays and the
// expected verdicts come from polynomial long division over each block.
module tb_crc_check_mblk;

  localparam int DATA_W      = 62;
  localparam int FRAME_BEATS = 26;
  localparam int NBLK        = 4;
  localparam int CRC_W       = 10;
  localparam int FRAME_BITS  = FRAME_BEATS * DATA_W;
  localparam logic [9:0] POLY = 10'b1000110011;

  logic              clk = 1'b0;
  logic              rst, crc_en, frame_tail_flag, cnt_clr;
  logic [DATA_W-1:0] crc_data_in;
  logic              check_valid, check_result, frame_len_err;
  logic [NBLK-1:0]   blk_fail;
  logic [22:0]       error_packet_cnt;
  logic              s_check_valid, s_check_result, s_frame_len_err;
  logic [NBLK-1:0]   s_blk_fail;
  logic [2:0]        s_error_packet_cnt;

  always #5 clk = ~clk;

  crc_check_mblk u_dut (
    .clk_390p625M(clk), .rst(rst), .crc_en(crc_en), .crc_data_in(crc_data_in),
    .frame_tail_flag(frame_tail_flag), .cnt_clr(cnt_clr),
    .check_valid(check_valid), .check_result(check_result), .blk_fail(blk_fail),
    .frame_len_err(frame_len_err), .error_packet_cnt(error_packet_cnt)
  );

  crc_check_mblk #(.CNT_W(3)) u_sat (
    .clk_390p625M(clk), .rst(rst), .crc_en(crc_en), .crc_data_in(crc_data_in),
    .frame_tail_flag(frame_tail_flag), .cnt_clr(cnt_clr),
    .check_valid(s_check_valid), .check_result(s_check_result), .blk_fail(s_blk_fail),
    .frame_len_err(s_frame_len_err), .error_packet_cnt(s_error_packet_cnt)
  );

  int          blen[NBLK] = '{390, 378, 400, 400};
  int          pstart[NBLK];
  int          cstart[NBLK];
  bit          fbits[FRAME_BITS];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned exp_cnt = 0;
  int unsigned exp_sat = 0;
  logic        exp_res = 1'b1;
  logic [3:0]  exp_blk = 4'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Remainder of payload * x^CRC_W modulo P by schoolbook division.
  function automatic logic [9:0] ref_crc(input int b);
    bit         m[$];
    logic [10:0] gen;
    logic [9:0]  r;
    gen = {1'b1, POLY};
    for (int i = 0; i < blen[b]; i++) m.push_back(fbits[pstart[b] + i]);
    for (int i = 0; i < CRC_W; i++) m.push_back(1'b0);
    for (int i = 0; i < blen[b]; i++)
      if (m[i]) for (int k = 0; k <= CRC_W; k++) m[i+k] = m[i+k] ^ gen[CRC_W-k];
    r = '0;
    for (int k = 0; k < CRC_W; k++) r[CRC_W-1-k] = m[blen[b] + k];
    return r;
  endfunction

  function automatic logic [9:0] get_field(input int b);
    logic [9:0] r;
    for (int k = 0; k < CRC_W; k++) r[CRC_W-1-k] = fbits[cstart[b] + k];
    return r;
  endfunction

  task automatic put_field(input int b, input logic [9:0] v);
    for (int k = 0; k < CRC_W; k++) fbits[cstart[b] + k] = v[CRC_W-1-k];
  endtask

  function automatic logic [DATA_W-1:0] beat_data(input int i);
    logic [DATA_W-1:0] d;
    for (int j = 0; j < DATA_W; j++) d[DATA_W-1-j] = fbits[i*DATA_W + j];
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] rand_word();
    return DATA_W'({$urandom, $urandom});
  endfunction

  task automatic clear_frame();
    for (int s = 0; s < FRAME_BITS; s++) fbits[s] = 1'b0;
  endtask

  task automatic build_rand(input bit allow_bad);
    logic [9:0] c;
    for (int s = 0; s < FRAME_BITS; s++) fbits[s] = 1'($urandom);
    for (int b = 0; b < NBLK; b++) begin
      c = ref_crc(b);
      if (allow_bad && $urandom_range(0, 2) == 0) c = c ^ 10'($urandom_range(1, 1023));
      put_field(b, c);
    end
  endtask

  task automatic cyc(input logic [DATA_W-1:0] d, input logic tail, input logic en,
                     input logic clr, input logic r);
    crc_data_in     = d;
    frame_tail_flag = tail;
    crc_en          = en;
    cnt_clr         = clr;
    rst             = r;
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_valid"},  32'(check_valid),   32'd0);
    check({tag, "_result"}, 32'(check_result),  32'd1);
    check({tag, "_blk"},    32'(blk_fail),      32'd0);
    check({tag, "_lerr"},   32'(frame_len_err), 32'd0);
    check({tag, "_cnt"},    32'(error_packet_cnt),   32'd0);
    check({tag, "_satcnt"}, 32'(s_error_packet_cnt), 32'd0);
  endtask

  // tail_at: beat carrying the tail flag (>= FRAME_BEATS means no tail at all).
  // stall_mode: 0 none, 1 fixed 3-cycle stalls before beats 13 and 25, 2 random.
  task automatic send_frame(input int tail_at, input int stall_mode, input bit clr_at_v);
    int         vat, nst;
    bit         lerr;
    logic [3:0] f;
    vat  = (tail_at < FRAME_BEATS - 1) ? tail_at : FRAME_BEATS - 1;
    lerr = (tail_at != FRAME_BEATS - 1);
    for (int b = 0; b < NBLK; b++) f[b] = (get_field(b) != ref_crc(b));
    exp_res = !lerr && (f == 4'h0);
    exp_blk = lerr ? 4'hF : f;
    for (int i = 0; i <= vat; i++) begin
      nst = 0;
      if (stall_mode == 1 && (i == 13 || i == 25)) nst = 3;
      if (stall_mode == 2) nst = int'($urandom_range(0, 2));
      for (int k = 0; k < nst; k++) begin
        cyc(rand_word(), 1'($urandom), 1'b0, 1'b0, 1'b0);
        check("stall_valid", 32'(check_valid), 32'd0);
      end
      cyc(beat_data(i), (i == tail_at), 1'b1, clr_at_v && (i == vat), 1'b0);
      if (i == vat) begin
        if (!exp_res) begin
          exp_cnt = clr_at_v ? 1 : exp_cnt + 1;
          exp_sat = clr_at_v ? 1 : (exp_sat < 7 ? exp_sat + 1 : 7);
        end else if (clr_at_v) begin
          exp_cnt = 0;
          exp_sat = 0;
        end
        check("verdict_valid", 32'(check_valid),   32'd1);
        check("result",        32'(check_result),  32'(exp_res));
        check("blk_fail",      32'(blk_fail),      32'(exp_blk));
        check("len_err",       32'(frame_len_err), 32'(lerr));
        check("cnt",           32'(error_packet_cnt),   exp_cnt);
        check("sat_cnt",       32'(s_error_packet_cnt), exp_sat);
      end else begin
        check("beat_valid", 32'(check_valid), 32'd0);
      end
    end
    cyc(rand_word(), 1'($urandom), 1'b0, 1'b0, 1'b0);
    check("post_valid",  32'(check_valid),  32'd0);
    check("hold_result", 32'(check_result), 32'(exp_res));
    check("hold_blk",    32'(blk_fail),     32'(exp_blk));
  endtask

  initial begin
    int acc;
    acc = 0;
    for (int b = 0; b < NBLK; b++) begin
      pstart[b] = acc;
      acc += blen[b];
    end
    for (int b = 0; b < NBLK; b++) cstart[b] = acc + b * CRC_W;

    crc_data_in = '0; frame_tail_flag = 1'b0; crc_en = 1'b0; cnt_clr = 1'b0; rst = 1'b1;
    @(negedge clk);
    cyc('0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset_checks("reset");

    clear_frame();
    send_frame(FRAME_BEATS - 1, 0, 1'b0);

    clear_frame();
    fbits[pstart[2] + blen[2] - 1] = 1'b1;
    put_field(2, POLY);
    send_frame(FRAME_BEATS - 1, 0, 1'b0);
    put_field(2, 10'h000);
    send_frame(FRAME_BEATS - 1, 0, 1'b0);
    check("b2_bad_blk", 32'(blk_fail), 32'h4);

    clear_frame();
    send_frame(FRAME_BEATS - 1, 1, 1'b0);

    send_frame(10, 0, 1'b0);
    build_rand(1'b0);
    send_frame(FRAME_BEATS - 1, 0, 1'b0);
    send_frame(FRAME_BEATS + 5, 0, 1'b0);

    for (int n = 0; n < 14; n++) begin
      build_rand(1'b1);
      if ($urandom_range(0, 3) == 0) send_frame(int'($urandom_range(0, 30)), 2, 1'b0);
      else send_frame(FRAME_BEATS - 1, 2, 1'b0);
    end

    cyc(rand_word(), 1'b0, 1'b0, 1'b1, 1'b0);
    exp_cnt = 0;
    exp_sat = 0;
    check("clr_cnt",    32'(error_packet_cnt),   32'd0);
    check("clr_satcnt", 32'(s_error_packet_cnt), 32'd0);
    for (int n = 0; n < 9; n++) send_frame(0, 0, 1'b0);
    check("sat_hold",  32'(s_error_packet_cnt), 32'd7);
    check("wide_nine", 32'(error_packet_cnt),   32'd9);
    build_rand(1'b0);
    send_frame(3, 0, 1'b1);

    build_rand(1'b0);
    for (int i = 0; i < 15; i++) begin
      cyc(beat_data(i), 1'b0, 1'b1, 1'b0, 1'b0);
      check("pre_rst_valid", 32'(check_valid), 32'd0);
    end
    cyc(beat_data(15), 1'b0, 1'b1, 1'b0, 1'b1);
    reset_checks("midrst");
    exp_cnt = 0; exp_sat = 0;
    cyc(rand_word(), 1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst_quiet", 32'(check_valid), 32'd0);
    build_rand(1'b0);
    send_frame(FRAME_BEATS - 1, 0, 1'b0);
    check("after_rst_pass", 32'(check_result), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
